// File: rtl/zhang_cnn_qmul_pkg.sv
// Shared widths, payload type and constant helpers for the quantized multiplier pipeline.
package zhang_cnn_qmul_pkg;

  // Payload fields are sized for the widest configuration; unused upper bits stay zero.
  localparam int DATA_MAX_W = 128;
  localparam int TAG_MAX_W  = 32;

  typedef struct packed {
    logic [DATA_MAX_W-1:0] data;
    logic [TAG_MAX_W-1:0]  tag;
    logic                  ovf;
  } stage_pl_t;

  function automatic int prod_w(input int a_w, input int b_w);
    return a_w + b_w + 1;
  endfunction

  function automatic logic [DATA_MAX_W-1:0] round_const(input int shift);
    logic [DATA_MAX_W-1:0] c;
    c = '0;
    if (shift > 0) c = DATA_MAX_W'(1) << (shift - 1);
    return c;
  endfunction

  function automatic logic signed [DATA_MAX_W-1:0] sat_max(input int out_w);
    return (DATA_MAX_W'(1) << (out_w - 1)) - DATA_MAX_W'(1);
  endfunction

  function automatic logic signed [DATA_MAX_W-1:0] sat_min(input int out_w);
    return -(DATA_MAX_W'(1) << (out_w - 1));
  endfunction

endpackage

// File: rtl/zhang_cnn_qmul_stage.sv
// One valid/ready register slice; payload only updates when a valid beat loads.
module zhang_cnn_qmul_stage
  import zhang_cnn_qmul_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      load,
  input  logic      d_vld,
  input  stage_pl_t d,
  output logic      q_vld,
  output stage_pl_t q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_vld <= 1'b0;
      q     <= '0;
    end else if (load) begin
      q_vld <= d_vld;
      if (d_vld) q <= d;
    end
  end

endmodule

// File: rtl/zhang_cnn_qmul_pipe.sv
// Pipelined fixed-point multiply/round/narrow with tag sideband, NUM_STAGE cycles, bubble-collapsing valid/ready.
// Define ZHANG_CNN_QMUL_SAT_EN for saturating narrowing and out_ovf; otherwise results wrap and out_ovf=0.
module zhang_cnn_qmul_pipe
  import zhang_cnn_qmul_pkg::*;
#(
  parameter int A_W       = 7,
  parameter int A_SIGNED  = 0,
  parameter int B_W       = 16,
  parameter int B_SIGNED  = 1,
  parameter int OUT_W     = 16,
  parameter int SHIFT     = 0,
  parameter int NUM_STAGE = 1,
  parameter int TAG_W     = 1
) (
  input  logic             ap_clk,
  input  logic             ap_rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [A_W-1:0]   in_a,
  input  logic [B_W-1:0]   in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_p,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_ovf
);

  // One guard bit above the full product so the rounding add cannot overflow.
  localparam int RW = prod_w(A_W, B_W) + 1;
  localparam int XW = (RW > OUT_W) ? RW : OUT_W;
  localparam logic signed [RW-1:0] RND = RW'(round_const(SHIFT));
`ifdef ZHANG_CNN_QMUL_SAT_EN
  localparam logic signed [XW-1:0] SMAX = XW'(sat_max(OUT_W));
  localparam logic signed [XW-1:0] SMIN = XW'(sat_min(OUT_W));
`endif

  function automatic logic signed [RW-1:0] qmul(input logic [A_W-1:0] a, input logic [B_W-1:0] b);
    logic signed [RW-1:0] ea;
    logic signed [RW-1:0] eb;
    if (A_SIGNED != 0) ea = RW'($signed(a)); else ea = RW'(a);
    if (B_SIGNED != 0) eb = RW'($signed(b)); else eb = RW'(b);
    return (ea * eb + RND) >>> SHIFT;
  endfunction

  // Returns {ovf, result}.
  function automatic logic [OUT_W:0] narrow(input logic signed [RW-1:0] r);
`ifdef ZHANG_CNN_QMUL_SAT_EN
    if (XW'(r) > SMAX) return {1'b1, SMAX[OUT_W-1:0]};
    if (XW'(r) < SMIN) return {1'b1, SMIN[OUT_W-1:0]};
`endif
    return {1'b0, OUT_W'(XW'(r))};
  endfunction

  stage_pl_t [NUM_STAGE-1:0] q;
  logic      [NUM_STAGE-1:0] vld;
  logic      [NUM_STAGE-1:0] load;

  always_comb begin
    load = '0;
    load[NUM_STAGE-1] = !vld[NUM_STAGE-1] || out_ready;
    for (int k = NUM_STAGE - 2; k >= 0; k--) load[k] = !vld[k] || load[k+1];
  end

  for (genvar k = 0; k < NUM_STAGE; k++) begin : g_stage
    stage_pl_t d;
    logic      d_vld;

    if (k == 0) begin : g_first
      assign d_vld = in_valid;
      always_comb begin
        d = '0;
        d.tag[TAG_W-1:0] = in_tag;
        if (NUM_STAGE == 1) {d.ovf, d.data[OUT_W-1:0]} = narrow(qmul(in_a, in_b));
        else d.data[A_W+B_W-1:0] = {in_a, in_b};
      end
    end else begin : g_next
      logic signed [RW-1:0] r;
      assign d_vld = vld[k-1];
      // Stage 2 multiplies registered operands; later stages carry the rounded product.
      always_comb begin
        if (k == 1) r = qmul(q[0].data[A_W+B_W-1:B_W], q[0].data[B_W-1:0]);
        else        r = q[k-1].data[RW-1:0];
        d = '0;
        d.tag = q[k-1].tag;
        if (k == NUM_STAGE - 1) {d.ovf, d.data[OUT_W-1:0]} = narrow(r);
        else d.data[RW-1:0] = r;
      end
    end

    zhang_cnn_qmul_stage u_stage (
      .clk  (ap_clk),
      .rst  (ap_rst),
      .load (load[k]),
      .d_vld(d_vld),
      .d    (d),
      .q_vld(vld[k]),
      .q    (q[k])
    );
  end

  assign in_ready  = load[0];
  assign out_valid = vld[NUM_STAGE-1];
  assign out_p     = q[NUM_STAGE-1].data[OUT_W-1:0];
  assign out_tag   = q[NUM_STAGE-1].tag[TAG_W-1:0];
`ifdef ZHANG_CNN_QMUL_SAT_EN
  assign out_ovf   = q[NUM_STAGE-1].ovf;
`else
  assign out_ovf   = 1'b0;
`endif

  logic unused_q;
  assign unused_q = ^q;

endmodule

// File: tb/tb_zhang_cnn_qmul_pipe.sv
// Bench: default-parameter instance plus a 3-stage signed/rounding instance, checked against an arithmetic model.
module tb_zhang_cnn_qmul_pipe;

  logic ap_clk, ap_rst;

  logic        v0, r0, ov0, or0, ovf0;
  logic [6:0]  a0;
  logic [15:0] b0, p0;
  logic [0:0]  t0, ot0;

  logic        v1, r1, ov1, or1, ovf1;
  logic [7:0]  a1;
  logic [15:0] b1, p1;
  logic [3:0]  t1, ot1;

  zhang_cnn_qmul_pipe dut0 (
    .ap_clk(ap_clk), .ap_rst(ap_rst),
    .in_valid(v0), .in_ready(r0), .in_a(a0), .in_b(b0), .in_tag(t0),
    .out_valid(ov0), .out_ready(or0), .out_p(p0), .out_tag(ot0), .out_ovf(ovf0)
  );

  zhang_cnn_qmul_pipe #(
    .A_W(8), .A_SIGNED(1), .B_W(16), .B_SIGNED(1), .OUT_W(16),
    .SHIFT(4), .NUM_STAGE(3), .TAG_W(4)
  ) dut1 (
    .ap_clk(ap_clk), .ap_rst(ap_rst),
    .in_valid(v1), .in_ready(r1), .in_a(a1), .in_b(b1), .in_tag(t1),
    .out_valid(ov1), .out_ready(or1), .out_p(p1), .out_tag(ot1), .out_ovf(ovf1)
  );

  initial ap_clk = 1'b0;
  always #5 ap_clk = ~ap_clk;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;

  typedef struct {
    logic [15:0] p;
    logic [3:0]  tag;
    logic        ovf;
    int          c;
  } exp_t;
  exp_t sb[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Full-precision product, round half up, then narrow to 16 bits.
  function automatic void qmodel(input longint a, input longint b, input int shift,
                                 output logic [15:0] p, output logic ovf);
    longint f;
    f = a * b;
    if (shift > 0) f = (f + (longint'(1) << (shift - 1))) >>> shift;
`ifdef ZHANG_CNN_QMUL_SAT_EN
    if (f > 32767)       begin p = 16'h7fff; ovf = 1'b1; end
    else if (f < -32768) begin p = 16'h8000; ovf = 1'b1; end
    else                 begin p = 16'(f);   ovf = 1'b0; end
`else
    p = 16'(f);
    ovf = 1'b0;
`endif
  endfunction

  // One cycle of dut1 with inputs already driven; scoreboard + occupancy model.
  task automatic cyc1(output bit acc);
    exp_t e;
    logic [15:0] hp;
    logic [3:0]  ht;
    bit hold;
    #1;
    check("dut1_in_ready", r1, (sb.size() < 3) || or1);
    check("dut1_out_valid", ov1, (sb.size() > 0) && (cyc - sb[0].c >= 3));
    hold = ov1 && !or1;
    hp = p1;
    ht = ot1;
    if (ov1 && or1 && sb.size() > 0) begin
      check("dut1_p", p1, sb[0].p);
      check("dut1_tag", ot1, sb[0].tag);
      check("dut1_ovf", ovf1, sb[0].ovf);
      void'(sb.pop_front());
    end
    acc = v1 && r1;
    if (acc) begin
      qmodel(longint'($signed(a1)), longint'($signed(b1)), 4, e.p, e.ovf);
      e.tag = t1;
      e.c = cyc;
      sb.push_back(e);
    end
    @(posedge ap_clk);
    #1;
    cyc++;
    if (hold) begin
      check("dut1_hold_valid", ov1, 1);
      check("dut1_hold_p", p1, hp);
      check("dut1_hold_tag", ot1, ht);
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [15:0] ep, wrap_ovf;
    logic        eo;
    bit          acc;
    int          nxt;

    ap_rst = 1'b1;
    v0 = 0; a0 = '0; b0 = '0; t0 = '0; or0 = 1;
    v1 = 0; a1 = '0; b1 = '0; t1 = '0; or1 = 1;
    repeat (2) @(posedge ap_clk);
    #1;
    check("rst_out_valid0", ov0, 0);
    check("rst_out_p0", p0, 0);
    check("rst_out_tag0", ot0, 0);
    check("rst_out_ovf0", ovf0, 0);
    check("rst_out_valid1", ov1, 0);
    check("rst_out_p1", p1, 0);
    ap_rst = 1'b0;
    @(posedge ap_clk);
    #1;
    check("post_rst_ready0", r0, 1);
    check("post_rst_ready1", r1, 1);

    // Defaults: 100 x -300 in one cycle.
    v0 = 1; a0 = 7'd100; b0 = -16'sd300; t0 = 1'b1;
    @(posedge ap_clk);
    #1;
    v0 = 0;
    check("dflt_valid", ov0, 1);
    check("dflt_p", p0, 16'h8ad0);
    check("dflt_tag", ot0, 1);
    check("dflt_ovf", ovf0, 0);
    @(posedge ap_clk);
    #1;
    check("dflt_single_beat", ov0, 0);

    // 127 x 300 = 38100 leaves the signed 16-bit range.
    v0 = 1; a0 = 7'd127; b0 = 16'd300; t0 = 1'b0;
    @(posedge ap_clk);
    #1;
    v0 = 0;
`ifdef ZHANG_CNN_QMUL_SAT_EN
    check("ovf_p", p0, 16'h7fff);
    check("ovf_flag", ovf0, 1);
`else
    wrap_ovf = -16'sd27436;
    check("ovf_p", p0, wrap_ovf);
    check("ovf_flag", ovf0, 0);
`endif

    // Random back-to-back stream on the default instance.
    for (int i = 0; i < 20; i++) begin
      v0 = 1; a0 = 7'($urandom); b0 = 16'($urandom); t0 = 1'(i);
      qmodel(longint'(a0), longint'($signed(b0)), 0, ep, eo);
      #1;
      check("rnd_ready0", r0, 1);
      @(posedge ap_clk);
      #1;
      check("rnd_valid0", ov0, 1);
      check("rnd_p0", p0, ep);
      check("rnd_tag0", ot0, t0);
      check("rnd_ovf0", ovf0, eo);
    end
    v0 = 0;

    // Rounding on the 3-stage instance.
    or1 = 1;
    v1 = 1; a1 = 8'sd3;  b1 = -16'sd5; t1 = 4'd1; cyc1(acc);
    v1 = 1; a1 = 8'sd1;  b1 = 16'sd8;  t1 = 4'd2; cyc1(acc);
    v1 = 1; a1 = -8'sd1; b1 = 16'sd8;  t1 = 4'd3; cyc1(acc);
    v1 = 0;
    check("round_neg", p1, 16'hffff);
    cyc1(acc);
    check("round_half_up", p1, 16'd1);
    cyc1(acc);
    check("round_neg_half", p1, 16'd0);
    repeat (2) cyc1(acc);

    // Back-pressure: tags 0..9 with out_ready pattern 1,0,0,1.
    nxt = 0;
    for (int i = 0; i < 120 && (nxt < 10 || sb.size() > 0); i++) begin
      or1 = (i % 4 == 0) || (i % 4 == 3);
      v1 = (nxt < 10);
      a1 = 8'($urandom); b1 = 16'($urandom); t1 = 4'(nxt);
      cyc1(acc);
      if (acc) nxt++;
    end
    v1 = 0;
    check("bp_all_sent", nxt, 10);
    check("bp_all_drained", sb.size(), 0);

    // Bubble collapse with out_ready held low.
    or1 = 0;
    v1 = 1; a1 = 8'($urandom); b1 = 16'($urandom); t1 = 4'd11; cyc1(acc);
    v1 = 0; cyc1(acc);
    v1 = 1; a1 = 8'($urandom); b1 = 16'($urandom); t1 = 4'd12; cyc1(acc);
    v1 = 0;
    repeat (3) cyc1(acc);
    check("bubble_ready_two_held", r1, 1);
    v1 = 1; a1 = 8'($urandom); b1 = 16'($urandom); t1 = 4'd13; cyc1(acc);
    v1 = 0;
    cyc1(acc);
    check("bubble_full_ready", r1, 0);
    or1 = 1;
    for (int i = 0; i < 10 && sb.size() > 0; i++) cyc1(acc);
    check("bubble_drained", sb.size(), 0);

    // Reset with two beats in flight.
    or1 = 0;
    v1 = 1; a1 = 8'($urandom); b1 = 16'($urandom); t1 = 4'd5; cyc1(acc);
    v1 = 1; a1 = 8'($urandom); b1 = 16'($urandom); t1 = 4'd6; cyc1(acc);
    v1 = 0;
    repeat (2) cyc1(acc);
    check("pre_rst_valid", ov1, 1);
    #2;
    ap_rst = 1'b1;
    #1;
    check("midrst_valid", ov1, 0);
    check("midrst_p", p1, 0);
    check("midrst_tag", ot1, 0);
    sb.delete();
    @(posedge ap_clk);
    #1;
    ap_rst = 1'b0;
    cyc++;
    or1 = 1;
    repeat (3) cyc1(acc);
    v1 = 1; a1 = 8'($urandom); b1 = 16'($urandom); t1 = 4'd9; cyc1(acc);
    v1 = 0;
    repeat (4) cyc1(acc);
    check("post_rst_drained", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
